// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator MAC engine: funct codes, instruction
// field positions, FSM state type and a magnitude helper.
package acc_pkg;

  localparam logic [5:0] FN_MACU = 6'd0;
  localparam logic [5:0] FN_MACS = 6'd1;
  localparam logic [5:0] FN_CLR  = 6'd2;
  localparam logic [5:0] FN_RDL  = 6'd3;
  localparam logic [5:0] FN_RDH  = 6'd4;

  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;
  localparam int unsigned FN_MSB = 5;
  localparam int unsigned FN_LSB = 0;

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_e;

  // 0x80000000 maps to itself, which is correct when read as unsigned 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/acc_seq_mul.sv
// Four-step 32x8 iterative unsigned multiplier: one byte of B per cycle after start.
module acc_seq_mul
  import acc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] prod_o,
  output logic        last_o
);

  logic [31:0] a_q, b_q;
  logic [63:0] prod_q, prod_d;
  logic [1:0]  cnt_q;
  logic        active_q;
  logic [7:0]  b_byte;
  logic [39:0] partial;

  always_comb begin
    b_byte  = b_q[{cnt_q, 3'b000} +: 8];
    partial = {8'b0, a_q} * {32'b0, b_byte};
    prod_d  = prod_q + ({24'b0, partial} << {cnt_q, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      a_q      <= a_i;
      b_q      <= b_i;
      prod_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      prod_q <= prod_d;
      cnt_q  <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) active_q <= 1'b0;
    end
  end

  assign prod_o = prod_q;
  // High during the cycle whose edge performs the final step.
  assign last_o = active_q && (cnt_q == 2'd3);

endmodule

// File: rtl/acc_engine.sv
// Accelerator bypass responder: 64-bit MAC accumulator with CLR/RDL/RDH, fed by a
// one-cycle instruction hand-off; all outputs registered.
module acc_engine
  import acc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accbypassA,
  input  logic [31:0] fullinstructionA,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_illegal,
  output logic        overrun
);

  state_e      state_q;
  logic [63:0] acc_q;
  logic        sign_q;
  logic        busy_q, done_q, wb_valid_q, err_q, overrun_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic [5:0]  funct;
  logic [4:0]  rd;
  logic        is_mac, is_macs, mul_start, mul_last;
  logic [31:0] op_a, op_b;
  logic [63:0] prod;

  always_comb begin
    funct     = fullinstructionA[FN_MSB:FN_LSB];
    rd        = fullinstructionA[RD_MSB:RD_LSB];
    is_macs   = (funct == FN_MACS);
    is_mac    = (funct == FN_MACU) || is_macs;
    mul_start = (state_q == IDLE) && accbypassA && is_mac;
    op_a      = is_macs ? mag32(rs_data) : rs_data;
    op_b      = is_macs ? mag32(rt_data) : rt_data;
  end

  acc_seq_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (mul_start),
    .a_i     (op_a),
    .b_i     (op_b),
    .prod_o  (prod),
    .last_o  (mul_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sign_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accbypassA) begin
            if (is_mac) begin
              sign_q  <= is_macs && (rs_data[31] ^ rt_data[31]);
              busy_q  <= 1'b1;
              state_q <= MUL;
            end else begin
              done_q <= 1'b1;
              case (funct)
                FN_CLR: acc_q <= '0;
                FN_RDL: begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd;
                  wb_data_q  <= acc_q[31:0];
                end
                FN_RDH: begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd;
                  wb_data_q  <= acc_q[63:32];
                end
                default: err_q <= 1'b1;
              endcase
            end
          end
        end
        MUL: begin
          if (accbypassA) overrun_q <= 1'b1;
          if (mul_last) state_q <= ADD;
        end
        ADD: begin
          if (accbypassA) overrun_q <= 1'b1;
          acc_q   <= sign_q ? (acc_q - prod) : (acc_q + prod);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign err_illegal = err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_acc_engine.sv
// Scoreboard bench for acc_engine: stimulus pushes expected done responses,
// a negedge monitor pops and compares them.
module tb_acc_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        accbypassA;
  logic [31:0] fullinstructionA, rs_data, rt_data;
  logic        busy, done, wb_valid, err_illegal, overrun;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct {
    logic        wv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  acc_engine dut (
    .clk              (clk),
    .reset            (reset),
    .accbypassA       (accbypassA),
    .fullinstructionA (fullinstructionA),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .busy             (busy),
    .done             (done),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .err_illegal      (err_illegal),
    .overrun          (overrun)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, ".wb_valid"}, 64'(wb_valid), 64'(e.wv));
        check({e.name, ".err_illegal"}, 64'(err_illegal), 64'(e.err));
        if (e.wv) begin
          check({e.name, ".wb_rd"}, 64'(wb_rd), 64'(e.rd));
          check({e.name, ".wb_data"}, 64'(wb_data), 64'(e.data));
        end
      end
    end
  end

  function automatic logic [31:0] instr(input logic [5:0] fn, input logic [4:0] rd);
    logic [31:0] v;
    v = 32'hA5A5_0000 & 32'hFFFF_07C0;  // junk in ignored bits
    v[15:11] = rd;
    v[5:0]   = fn;
    return v;
  endfunction

  task automatic push(input string nm, input logic wv, input logic [4:0] rd,
                      input logic [31:0] data, input logic err);
    exp_t e;
    e.wv = wv; e.rd = rd; e.data = data; e.err = err; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Called #1 after an edge; request is sampled at the next edge, returns #1 after it.
  task automatic send(input logic [5:0] fn, input logic [4:0] rd,
                      input logic [31:0] rs, input logic [31:0] rt);
    accbypassA       = 1'b1;
    fullinstructionA = instr(fn, rd);
    rs_data          = rs;
    rt_data          = rt;
    @(posedge clk); #1;
    accbypassA       = 1'b0;
    fullinstructionA = 32'hDEAD_BEEF;
    rs_data          = '0;
    rt_data          = '0;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check({nm, ".done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic mac(input string nm, input logic [5:0] fn,
                     input logic [31:0] rs, input logic [31:0] rt);
    int n;
    push(nm, 1'b0, 5'd0, 32'd0, 1'b0);
    send(fn, 5'd0, rs, rt);
    wait_done(nm, n);
  endtask

  task automatic single(input string nm, input logic [5:0] fn, input logic [4:0] rd,
                        input logic wv, input logic [31:0] data, input logic err);
    push(nm, wv, rd, data, err);
    send(fn, rd, 32'h1234_5678, 32'h9ABC_DEF0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".busy"}, 64'(busy), 64'd0);
    check({nm, ".done"}, 64'(done), 64'd0);
    check({nm, ".wb_valid"}, 64'(wb_valid), 64'd0);
    check({nm, ".wb_rd"}, 64'(wb_rd), 64'd0);
    check({nm, ".wb_data"}, 64'(wb_data), 64'd0);
    check({nm, ".err_illegal"}, 64'(err_illegal), 64'd0);
    check({nm, ".overrun"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    accbypassA = 1'b0;
    fullinstructionA = '0;
    rs_data = '0;
    rt_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("reset");

    // MACU 3*5, timing of busy/done, then RDL in the done cycle.
    push("macu_3x5", 1'b0, 5'd0, 32'd0, 1'b0);
    send(6'd0, 5'd0, 32'd3, 32'd5);
    check("macu.busy_after_e0", 64'(busy), 64'd1);
    wait_done("macu_3x5", n);
    check("macu.done_latency", 64'(n), 64'd5);
    check("macu.busy_in_done", 64'(busy), 64'd0);
    single("rdl_15", 6'd3, 5'd7, 1'b1, 32'd15, 1'b0);

    // MACS -2*7 from 15 -> 1.
    mac("macs_neg", 6'd1, 32'hFFFF_FFFE, 32'd7);
    single("rdl_1", 6'd3, 5'd1, 1'b1, 32'd1, 1'b0);
    single("rdh_0", 6'd4, 5'd2, 1'b1, 32'd0, 1'b0);

    // Wrap: 2 * 0xFFFFFFFF^2 mod 2^64 = 0xFFFFFFFC_00000002.
    single("clr_a", 6'd2, 5'd0, 1'b0, 32'd0, 1'b0);
    mac("macu_max1", 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mac("macu_max2", 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    single("rdh_wrap", 6'd4, 5'd30, 1'b1, 32'hFFFF_FFFC, 1'b0);
    single("rdl_wrap", 6'd3, 5'd31, 1'b1, 32'h0000_0002, 1'b0);

    // MACS with both operands at 0x80000000: +2^62.
    single("clr_b", 6'd2, 5'd0, 1'b0, 32'd0, 1'b0);
    mac("macs_min", 6'd1, 32'h8000_0000, 32'h8000_0000);
    single("rdh_min", 6'd4, 5'd9, 1'b1, 32'h4000_0000, 1'b0);

    // Overrun: second request at E2 is dropped.
    single("clr_c", 6'd2, 5'd0, 1'b0, 32'd0, 1'b0);
    push("macu_6x7", 1'b0, 5'd0, 32'd0, 1'b0);
    send(6'd0, 5'd0, 32'd6, 32'd7);
    check("ovr.before", 64'(overrun), 64'd0);
    @(posedge clk); #1;
    send(6'd0, 5'd0, 32'd100, 32'd100);
    check("ovr.set", 64'(overrun), 64'd1);
    wait_done("macu_6x7", n);
    single("rdl_42", 6'd3, 5'd4, 1'b1, 32'd42, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("ovr.sticky", 64'(overrun), 64'd1);

    // Illegal funct after CLR.
    single("clr_d", 6'd2, 5'd0, 1'b0, 32'd0, 1'b0);
    single("illegal", 6'h3F, 5'd5, 1'b0, 32'd0, 1'b1);
    single("rdl_after_clr", 6'd3, 5'd3, 1'b1, 32'd0, 1'b0);

    // Reset at E3 of a MAC abandons it.
    mac("macu_9x9", 6'd0, 32'd9, 32'd9);
    single("rdl_81", 6'd3, 5'd8, 1'b1, 32'd81, 1'b0);
    send(6'd0, 5'd0, 32'd2, 32'd3);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("mid_reset");
    repeat (8) @(posedge clk); #1;
    single("rdl_after_reset", 6'd3, 5'd6, 1'b1, 32'd0, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
